// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester data-memory port arbiter.
package mem_arb_pkg;

   localparam int AW_DEF      = 32;
   localparam int DW_DEF      = 32;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   // Width of a counter that must be able to count up to limit.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the shared memory port; the arbiter takes the
// slave view, the requesters/memory side takes the master view.
interface mem_port_arbiter_if #(
   parameter int AW = mem_arb_pkg::AW_DEF,
   parameter int DW = mem_arb_pkg::DW_DEF
) ();

   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_ack;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_ack;
   logic [DW-1:0] m1_rdata;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          timeout_err;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ack, m1_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output timeout_err
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ack, m1_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  timeout_err
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a tie goes to the requester not served last,
// a lone request wins outright.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between a CPU data port (m0) and a DMA/debug port (m1),
// one access at a time, with registered outputs and an optional ACCESS timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int            CW     = cnt_width(TIMEOUT);
   localparam logic [CW:0]   TO_LIM = (CW + 1)'(TIMEOUT);

   arb_state_t    state_q, state_d;
   logic          last_q, last_d;
   logic          gnt_q, gnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          tmo_q, tmo_d;

   logic          pick_id;
   logic [CW:0]   cnt_inc;
   logic          tmo_hit;
   logic [DW-1:0] rd_val;

   rr_pick2 u_pick (
      .req   ({bus.m1_req, bus.m0_req}),
      .last  (last_q),
      .grant (pick_id)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         tmo_q       <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      tmo_d       = 1'b0;
      cnt_inc     = {1'b0, cnt_q} + 1'b1;
      tmo_hit     = 1'b0;
      rd_val      = '0;

      case (state_q)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               gnt_d       = pick_id;
               mem_req_d   = 1'b1;
               mem_we_d    = pick_id ? bus.m1_we    : bus.m0_we;
               mem_addr_d  = pick_id ? bus.m1_addr  : bus.m0_addr;
               mem_wdata_d = pick_id ? bus.m1_wdata : bus.m0_wdata;
               cnt_d       = '0;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // mem_ready wins over a timeout landing on the same cycle.
            tmo_hit = (TIMEOUT != 0) && !bus.mem_ready && (cnt_inc == TO_LIM);
            if (bus.mem_ready || tmo_hit) begin
               rd_val = bus.mem_ready ? bus.mem_rdata : '0;
               if (gnt_q) begin
                  rdata1_d = rd_val;
                  ack1_d   = 1'b1;
               end else begin
                  rdata0_d = rd_val;
                  ack0_d   = 1'b1;
               end
               tmo_d     = tmo_hit;
               mem_req_d = 1'b0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         DONE: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.m0_ack      = ack0_q;
   assign bus.m1_ack      = ack1_q;
   assign bus.m0_rdata    = rdata0_q;
   assign bus.m1_rdata    = rdata1_q;
   assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random
// traffic scored every cycle against a transaction-level schedule model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 15;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   bit            chk_on   = 1'b0;
   bit            rand_on  = 1'b0;
   bit            noise_on = 1'b1;
   bit            fix_on   = 1'b0;
   logic [DW-1:0] fix_val  = '0;
   int            lat_plan = 0;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory wait states: mostly short, with the timeout edges picked deliberately.
   function automatic int pick_lat();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)  return $urandom_range(0, 3);
      if (r == 6) return TMO - 1;
      if (r == 7) return TMO;
      if (r == 8) return 1000;
      return $urandom_range(4, 12);
   endfunction

   // ---------------- memory responder ----------------
   initial begin
      int   j;
      int   lat_cur;
      logic prev;
      j = 0; lat_cur = 0; prev = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && !prev) begin
            j = 1;
            lat_cur = lat_plan;
            if (rand_on) lat_plan = pick_lat();
         end else if (bus.mem_req) begin
            j++;
         end
         prev = bus.mem_req;
         bus.mem_rdata = fix_on ? fix_val : DW'($urandom);
         if (bus.mem_req) bus.mem_ready = (j == lat_cur + 1);
         else             bus.mem_ready = noise_on && ($urandom_range(0, 1) == 1);
      end
   end

   // ---------------- schedule model ----------------
   // A transaction decided at edge s with L wait states occupies k ACCESS cycles,
   // k = L+1 if that fits within TMO (or no timeout), else TMO; ack follows, then idle.
   bit            busy;
   int            owner, last_srv, age, k;
   bit            ok;
   logic          exp_mem_req, exp_we, exp_tmo;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   logic [1:0]    exp_ack;
   logic [DW-1:0] exp_rd0, exp_rd1;

   task automatic model_reset();
      busy = 1'b0; owner = 0; last_srv = 1; age = 0; k = 0; ok = 1'b1;
      exp_mem_req = 1'b0; exp_we = 1'b0; exp_tmo = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_ack = 2'b00;
      exp_rd0 = '0; exp_rd1 = '0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            model_reset();
         end else if (!busy) begin
            if (bus.m0_req || bus.m1_req) begin
               if (bus.m0_req && bus.m1_req) owner = 1 - last_srv;
               else                          owner = bus.m1_req ? 1 : 0;
               ok          = (TMO == 0) || (lat_plan + 1 <= TMO);
               k           = ok ? lat_plan + 1 : TMO;
               age         = 0;
               busy        = 1'b1;
               exp_mem_req = 1'b1;
               exp_we      = owner == 1 ? bus.m1_we    : bus.m0_we;
               exp_addr    = owner == 1 ? bus.m1_addr  : bus.m0_addr;
               exp_wdata   = owner == 1 ? bus.m1_wdata : bus.m0_wdata;
            end
         end else begin
            age++;
            if (age == k) begin
               exp_mem_req    = 1'b0;
               exp_ack[owner] = 1'b1;
               exp_tmo        = !ok;
               if (owner == 1) exp_rd1 = ok ? bus.mem_rdata : '0;
               else            exp_rd0 = ok ? bus.mem_rdata : '0;
            end else if (age == k + 1) begin
               exp_ack  = 2'b00;
               exp_tmo  = 1'b0;
               last_srv = owner;
               busy     = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on && reset) begin
         check("cyc_mem_req", bus.mem_req, exp_mem_req);
         if (exp_mem_req) begin
            check("cyc_mem_we", bus.mem_we, exp_we);
            check("cyc_mem_addr", bus.mem_addr, exp_addr);
            check("cyc_mem_wdata", bus.mem_wdata, exp_wdata);
         end
         check("cyc_m0_ack", bus.m0_ack, exp_ack[0]);
         check("cyc_m1_ack", bus.m1_ack, exp_ack[1]);
         check("cyc_timeout_err", bus.timeout_err, exp_tmo);
         check("cyc_m0_rdata", bus.m0_rdata, exp_rd0);
         check("cyc_m1_rdata", bus.m1_rdata, exp_rd1);
      end
   end

   // ---------------- requester helpers ----------------
   task automatic set_req(input int who, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
      if (who == 0) begin
         bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
      end else begin
         bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
      end
   endtask

   task automatic drop_req(input int who);
      if (who == 0) bus.m0_req = 1'b0;
      else          bus.m1_req = 1'b0;
   endtask

   task automatic set_rand(input int who);
      set_req(who, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic wait_any_ack(input int limit, output int who);
      who = -1;
      for (int c = 0; c < limit && who < 0; c++) begin
         @(negedge clk);
         if (bus.m0_ack)      who = 0;
         else if (bus.m1_ack) who = 1;
      end
      if (who < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_ack: no ack within %0d cycles", limit);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int order [3];
      int who, hi, acks, tmos;
      bit seen;
      logic tmo_at_ack;

      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_acks", {bus.m0_ack, bus.m1_ack}, 0);
      check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
      check("rst_timeout_err", bus.timeout_err, 0);
      #2 reset = 1'b1;
      chk_on = 1'b1;

      // Test 1: m0 write, ready one cycle after mem_req
      lat_plan = 1;
      @(negedge clk);
      set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_mem_req", bus.mem_req, 1);
      check("t1_mem_we", bus.mem_we, 1);
      check("t1_mem_addr", bus.mem_addr, 32'h10);
      check("t1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_ack_early", bus.m0_ack, 0);
      check("t1_mem_req_held", bus.mem_req, 1);
      @(negedge clk);
      check("t1_m0_ack", bus.m0_ack, 1);
      check("t1_m1_ack", bus.m1_ack, 0);
      check("t1_mem_req_low", bus.mem_req, 0);
      drop_req(0);
      @(negedge clk);
      check("t1_ack_pulse", bus.m0_ack, 0);

      // Test 2: ties from reset alternate m0, m1, m0
      apply_reset();
      lat_plan = 0;
      @(negedge clk);
      set_req(0, 1'b0, 32'h100, '0);
      set_req(1, 1'b0, 32'h200, '0);
      for (int g = 0; g < 3; g++) begin
         wait_any_ack(20, who);
         order[g] = who;
         if (who >= 0) set_req(who, 1'b0, AW'(32'h300 + g), '0);
      end
      drop_req(0);
      drop_req(1);
      check("t2_grant0", order[0], 0);
      check("t2_grant1", order[1], 1);
      check("t2_grant2", order[2], 0);

      // Test 3: m1 read with 5 wait states
      lat_plan = 5;
      fix_val  = 32'h12345678;
      fix_on   = 1'b1;
      @(negedge clk);
      set_req(1, 1'b0, 32'h20, '0);
      hi = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (bus.mem_req) hi++;
         if (bus.m1_ack)  seen = 1'b1;
      end
      check("t3_ack_seen", seen, 1);
      check("t3_req_cycles", hi, 6);
      check("t3_m1_rdata", bus.m1_rdata, 32'h12345678);
      check("t3_m0_ack", bus.m0_ack, 0);
      drop_req(1);
      @(negedge clk);
      check("t3_ack_pulse", bus.m1_ack, 0);
      fix_on = 1'b0;

      // Test 4: memory never answers
      lat_plan = 1000;
      @(negedge clk);
      set_req(0, 1'b0, 32'h44, '0);
      hi = 0; seen = 1'b0; tmo_at_ack = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (bus.mem_req) hi++;
         if (bus.m0_ack) begin
            seen = 1'b1;
            tmo_at_ack = bus.timeout_err;
         end
      end
      check("t4_ack_seen", seen, 1);
      check("t4_access_cycles", hi, 15);
      check("t4_timeout_err", tmo_at_ack, 1);
      check("t4_m0_rdata", bus.m0_rdata, 0);
      drop_req(0);
      @(negedge clk);
      check("t4_err_pulse", bus.timeout_err, 0);
      check("t4_idle", dut.state_q, IDLE);

      // Test 5: reset on the 2nd ACCESS cycle
      lat_plan = 10;
      @(negedge clk);
      set_req(0, 1'b1, 32'h50, 32'h5555);
      @(negedge clk);
      @(negedge clk);
      check("t5_in_access", bus.mem_req, 1);
      #2 reset = 1'b0;
      #1;
      check("t5_mem_req", bus.mem_req, 0);
      check("t5_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      check("t5_acks", {bus.m0_ack, bus.m1_ack, bus.timeout_err}, 0);
      check("t5_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
      drop_req(0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      acks = 0; tmos = 0;
      repeat (25) begin
         @(negedge clk);
         acks += int'(bus.m0_ack) + int'(bus.m1_ack);
         tmos += int'(bus.timeout_err);
      end
      check("t5_no_ack", acks, 0);
      check("t5_no_err", tmos, 0);

      // Test 6: m0 drops req mid-ACCESS
      lat_plan = 4;
      @(negedge clk);
      set_req(0, 1'b0, 32'h60, '0);
      repeat (2) @(negedge clk);
      drop_req(0);
      acks = 0;
      repeat (15) begin
         @(negedge clk);
         acks += int'(bus.m0_ack);
      end
      check("t6_one_ack", acks, 1);

      // Random traffic
      lat_plan = pick_lat();
      rand_on  = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (bus.m0_ack) begin
            if ($urandom_range(0, 1) == 1) set_rand(0);
            else drop_req(0);
         end else if (!bus.m0_req && $urandom_range(0, 2) == 0) begin
            set_rand(0);
         end
         if (bus.m1_ack) begin
            if ($urandom_range(0, 1) == 1) set_rand(1);
            else drop_req(1);
         end else if (!bus.m1_req && $urandom_range(0, 2) == 0) begin
            set_rand(1);
         end
      end
      drop_req(0);
      drop_req(1);
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
